// File: rtl/fifo_arb_pkg.sv
// Shared constants and width helpers for the round-robin FIFO drain scheduler.
package fifo_arb_pkg;

  // Scheduler states: ARB picks the next channel, GRANT pops from it.
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Number of bits needed to encode values 0..n-1, never less than one.
  function automatic int bits_for(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << w) < n) begin
        w = w + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: rotates the request vector so the channel after the
// last grant sits at bit 0, priority-encodes, then rotates the index back.
module fifo_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic              found,
  output logic [CH_W-1:0]   next_grant
);

  // One extra bit so start + offset (< 2*NUM_CH) never overflows.
  localparam int SW = CH_W + 1;

  logic [SW-1:0]     start_s;
  logic [NUM_CH-1:0] rot_s;
  logic [SW-1:0]     off_s;
  logic [SW-1:0]     sum_s;

  // Reduce a value below 2*NUM_CH into 0..NUM_CH-1 (works for any NUM_CH).
  function automatic logic [SW-1:0] wrap(input logic [SW-1:0] v);
    if (v >= SW'(NUM_CH)) begin
      return v - SW'(NUM_CH);
    end else begin
      return v;
    end
  endfunction

  // Search starts one past the previous grant.
  always_comb begin
    start_s = wrap({1'b0, last_grant} + SW'(1));
  end

  // Rotate right by start: rot_s[i] = req[(start + i) mod NUM_CH].
  always_comb begin
    rot_s = NUM_CH'({req, req} >> start_s);
  end

  // Lowest set bit of the rotated vector is the next in round-robin order.
  always_comb begin
    off_s = SW'(0);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = SW'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  // Undo the rotation to get the absolute channel index.
  always_comb begin
    sum_s      = wrap(start_s + off_s);
    next_grant = sum_s[CH_W-1:0];
    found      = |req;
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_CH FWFT FIFOs into one registered valid/ready
// stream, in bursts of up to BURST_LEN words per grant, tagged by channel.
module fifo_rr_drain
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 4,
  localparam int CH_W       = bits_for(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_empty_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]            ch_en_i,
  output logic [NUM_CH-1:0]            ch_rd_en_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [CH_W-1:0]              out_ch_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);

  localparam int CNT_W = bits_for(BURST_LEN + 1);

  logic [0:0]            state_r;
  logic [CH_W-1:0]       grant_r;
  logic [CH_W-1:0]       last_r;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [CH_W-1:0]       out_ch_r;
  logic                  out_valid_r;

  logic [NUM_CH-1:0]     req_s;
  logic                  req_g_s;
  logic                  slot_free_s;
  logic                  load_s;
  logic                  found_s;
  logic [CH_W-1:0]       pick_s;
  logic [CNT_W-1:0]      count_inc_s;
  logic                  burst_done_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  assign req_s        = ~ch_empty_i & ch_en_i;
  assign req_g_s      = req_s[grant_r];
  assign slot_free_s  = ~out_valid_r | out_ready_i;
  assign load_s       = (state_r == ST_GRANT) & req_g_s & slot_free_s;
  assign count_inc_s  = count_r + 1'b1;
  assign burst_done_s = (count_inc_s == CNT_W'(BURST_LEN));
  assign sel_data_s   = ch_data_i[grant_r*DATA_WIDTH +: DATA_WIDTH];

  fifo_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req        (req_s),
    .last_grant (last_r),
    .found      (found_s),
    .next_grant (pick_s)
  );

  // Pop strobe is combinational so the FIFO advances in the same cycle the word is captured.
  always_comb begin
    ch_rd_en_o = {NUM_CH{1'b0}};
    if (load_s) begin
      ch_rd_en_o[grant_r] = 1'b1;
    end else begin
      ch_rd_en_o = {NUM_CH{1'b0}};
    end
  end

  // Arbitration FSM: pick a channel, pop up to BURST_LEN words, release early if it stops requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_ARB;
      grant_r <= CH_W'(0);
      last_r  <= CH_W'(NUM_CH - 1);
      count_r <= CNT_W'(0);
    end else begin
      case (state_r)
        ST_ARB: begin
          if (found_s) begin
            grant_r <= pick_s;
            last_r  <= pick_s;
            count_r <= CNT_W'(0);
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_ARB;
          end
        end
        ST_GRANT: begin
          if (!req_g_s) begin
            state_r <= ST_ARB;
          end else if (load_s) begin
            count_r <= count_inc_s;
            if (burst_done_s) begin
              state_r <= ST_ARB;
            end else begin
              state_r <= ST_GRANT;
            end
          end else begin
            state_r <= ST_GRANT;
          end
        end
        default: begin
          state_r <= ST_ARB;
        end
      endcase
    end
  end

  // Output register: capture on pop, clear valid once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= DATA_WIDTH'(0);
      out_ch_r    <= CH_W'(0);
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= sel_data_s;
      out_ch_r    <= grant_r;
      out_valid_r <= 1'b1;
    end else if (out_ready_i && out_valid_r) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data_o  = out_data_r;
  assign out_ch_o    = out_ch_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = (state_r == ST_GRANT);

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Self-checking bench for fifo_rr_drain: table-driven picker vectors plus
// scenario sequences with FWFT FIFO models and an output scoreboard.
module tb_fifo_rr_drain;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int BL  = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    ch_empty;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    rd_en;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  logic [4:0] p_req;
  logic [2:0] p_last;
  logic       p_found;
  logic [2:0] p_idx;

  always #5 clk = ~clk;

  fifo_rr_drain #(.NUM_CH(NCH), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .ch_empty_i(ch_empty), .ch_data_i(ch_data),
    .ch_en_i(ch_en), .ch_rd_en_o(rd_en), .out_data_o(out_data), .out_ch_o(out_ch),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  // Standalone picker with a non-power-of-2 channel count.
  fifo_rr_pick #(.NUM_CH(5), .CH_W(3)) u_pick5 (
    .req(p_req), .last_grant(p_last), .found(p_found), .next_grant(p_idx)
  );

  typedef struct {
    logic [4:0] req;
    logic [2:0] last;
    logic       found;
    logic [2:0] idx;
  } pick_vec_t;

  pick_vec_t        tbl [9];
  logic [DW-1:0]    fq [NCH][$];
  logic [CW+DW-1:0] sb [$];
  logic [CW+DW-1:0] out_log [$];
  logic [CW+DW-1:0] exp_log [$];
  int               out_t [$];
  int               pop_cnt [NCH];
  int               cyc;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < NCH; k++) begin
      ch_empty[k] = (fq[k].size() == 0);
      ch_data[k*DW +: DW] = (fq[k].size() == 0) ? 8'h00 : fq[k][0];
    end
  endtask

  // One clock: check pops, feed scoreboard, advance FIFO models.
  task automatic step();
    logic [NCH-1:0]   popv;
    logic             legal;
    logic [CW+DW-1:0] e;
    #1;
    popv = rd_en;
    if (popv != 4'b0000) begin
      legal = ($countones(popv) == 1);
      for (int k = 0; k < NCH; k++) begin
        if (popv[k] && (fq[k].size() == 0 || !ch_en[k])) legal = 1'b0;
      end
      chk("pop_legal", {31'd0, legal}, 32'd1);
      for (int k = 0; k < NCH; k++) begin
        if (popv[k] && fq[k].size() > 0) sb.push_back({CW'(k), fq[k][0]});
      end
    end
    if (out_valid && out_ready) begin
      out_log.push_back({out_ch, out_data});
      out_t.push_back(cyc);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_word", {22'd0, out_ch, out_data}, {22'd0, e});
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (popv[k] && fq[k].size() > 0) begin
        fq[k].delete(0);
        pop_cnt[k]++;
      end
    end
    refresh();
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    ch_en     = 4'b1111;
    for (int k = 0; k < NCH; k++) begin
      fq[k].delete();
      pop_cnt[k] = 0;
    end
    sb.delete();
    out_log.delete();
    out_t.delete();
    exp_log.delete();
    cyc = 0;
    refresh();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst();
    refresh();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int b;
    b = 0;
    while (out_log.size() < n && b < budget) begin
      step();
      b++;
    end
    chk(name, out_log.size(), n);
  endtask

  task automatic cmp_log(input string name);
    chk({name, "_len"}, out_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < out_log.size()) chk(name, {22'd0, out_log[i]}, {22'd0, exp_log[i]});
    end
  endtask

  task automatic wait_pops(input int ch, input int n, input int budget);
    int b;
    b = 0;
    while (pop_cnt[ch] < n && b < budget) begin
      step();
      b++;
    end
    chk("wait_pops", pop_cnt[ch], n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int t_exp [6];
    rst_n = 1'b0;
    out_ready = 1'b1;
    ch_en = 4'b1111;
    p_req = 5'd0;
    p_last = 3'd0;
    refresh();

    // Picker vectors, NUM_CH=5: search starts at last+1 mod 5.
    tbl[0] = '{5'b00000, 3'd0, 1'b0, 3'd0};
    tbl[1] = '{5'b00001, 3'd4, 1'b1, 3'd0};
    tbl[2] = '{5'b10001, 3'd0, 1'b1, 3'd4};
    tbl[3] = '{5'b10001, 3'd4, 1'b1, 3'd0};
    tbl[4] = '{5'b00110, 3'd1, 1'b1, 3'd2};
    tbl[5] = '{5'b00110, 3'd2, 1'b1, 3'd1};
    tbl[6] = '{5'b11111, 3'd3, 1'b1, 3'd4};
    tbl[7] = '{5'b01000, 3'd3, 1'b1, 3'd3};
    tbl[8] = '{5'b00010, 3'd1, 1'b1, 3'd1};
    for (int i = 0; i < 9; i++) begin
      p_req  = tbl[i].req;
      p_last = tbl[i].last;
      #1;
      chk("pick_found", {31'd0, p_found}, {31'd0, tbl[i].found});
      if (tbl[i].found) chk("pick_idx", {29'd0, p_idx}, {29'd0, tbl[i].idx});
    end

    // 1: single requester ch2 with A0..A5, burst of 4, gap, then 2 more.
    reset_dut();
    for (int i = 0; i < 6; i++) fq[2].push_back(8'hA0 + 8'(i));
    refresh();
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_rd_en", {28'd0, rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    release_rst();
    step();
    chk("lat_busy_c1", {31'd0, busy}, 32'd1);
    chk("lat_valid_c1", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid_c2", {31'd0, out_valid}, 32'd1);
    chk("lat_data_c2", {24'd0, out_data}, 32'hA0);
    chk("lat_ch_c2", {30'd0, out_ch}, 32'd2);
    run_until("s1_count", 6, 40);
    for (int i = 0; i < 6; i++) exp_log.push_back({2'd2, 8'hA0 + 8'(i)});
    cmp_log("s1_word");
    t_exp = '{2, 3, 4, 5, 7, 8};
    for (int i = 0; i < 6; i++) begin
      if (i < out_t.size()) chk("s1_timing", out_t[i], t_exp[i]);
    end

    // 2: all four channels with 8 words each, 4-word bursts in order 0,1,2,3,0,...
    reset_dut();
    for (int k = 0; k < NCH; k++) begin
      for (int i = 0; i < 8; i++) fq[k].push_back(8'(k * 16 + i));
    end
    release_rst();
    run_until("s2_count", 32, 120);
    for (int j = 0; j < 32; j++) begin
      exp_log.push_back({2'((j / 4) % 4), 8'(((j / 4) % 4) * 16 + (j / 16) * 4 + (j % 4))});
    end
    cmp_log("s2_word");

    // 3: backpressure on ch1 mid-burst freezes pops and count.
    reset_dut();
    for (int i = 0; i < 8; i++) fq[1].push_back(8'h10 + 8'(i));
    release_rst();
    wait_pops(1, 2, 10);
    out_ready = 1'b0;
    repeat (5) step();
    chk("stall_pops", pop_cnt[1], 2);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_data", {24'd0, out_data}, 32'h11);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_accepted", out_log.size(), 1);
    out_ready = 1'b1;
    b = 0;
    while (busy && b < 10) begin
      step();
      b++;
    end
    chk("stall_burst_len", pop_cnt[1], 4);
    run_until("s3_count", 8, 40);
    for (int i = 0; i < 8; i++) exp_log.push_back({2'd1, 8'h10 + 8'(i)});
    cmp_log("s3_word");

    // 4: ch0 runs dry after two words, ch3 is next.
    reset_dut();
    fq[0].push_back(8'h01);
    fq[0].push_back(8'h02);
    for (int i = 0; i < 3; i++) fq[3].push_back(8'h31 + 8'(i));
    release_rst();
    run_until("s4_count", 5, 30);
    exp_log.push_back({2'd0, 8'h01});
    exp_log.push_back({2'd0, 8'h02});
    for (int i = 0; i < 3; i++) exp_log.push_back({2'd3, 8'h31 + 8'(i)});
    cmp_log("s4_word");
    if (out_t.size() > 2) chk("s4_ch3_first_t", out_t[2], 6);

    // 5: disabling ch1 mid-burst rotates to ch2; re-enable resumes ch1 in order.
    reset_dut();
    for (int i = 0; i < 8; i++) fq[1].push_back(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) fq[2].push_back(8'h20 + 8'(i));
    release_rst();
    wait_pops(1, 2, 10);
    ch_en[1] = 1'b0;
    wait_pops(2, 4, 20);
    chk("dis_no_pop", pop_cnt[1], 2);
    ch_en[1] = 1'b1;
    run_until("s5_count", 12, 60);
    exp_log.push_back({2'd1, 8'h10});
    exp_log.push_back({2'd1, 8'h11});
    for (int i = 0; i < 4; i++) exp_log.push_back({2'd2, 8'h20 + 8'(i)});
    for (int i = 2; i < 8; i++) exp_log.push_back({2'd1, 8'h10 + 8'(i)});
    cmp_log("s5_word");

    // 6: reset mid-burst clears outputs at once; ch0 still wins over ch3 afterwards.
    reset_dut();
    for (int i = 0; i < 8; i++) fq[0].push_back(8'h40 + 8'(i));
    for (int i = 0; i < 8; i++) fq[3].push_back(8'h70 + 8'(i));
    release_rst();
    wait_pops(0, 2, 10);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
    chk("arst_ch", {30'd0, out_ch}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rd_en", {28'd0, rd_en}, 32'd0);
    sb.delete();
    out_log.delete();
    out_t.delete();
    @(negedge clk);
    release_rst();
    run_until("s6_count", 14, 80);
    for (int i = 2; i < 6; i++) exp_log.push_back({2'd0, 8'h40 + 8'(i)});
    for (int i = 0; i < 4; i++) exp_log.push_back({2'd3, 8'h70 + 8'(i)});
    for (int i = 6; i < 8; i++) exp_log.push_back({2'd0, 8'h40 + 8'(i)});
    for (int i = 4; i < 8; i++) exp_log.push_back({2'd3, 8'h70 + 8'(i)});
    cmp_log("s6_word");
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
- Round-robin read scheduler that drains NUM_CH first-word-fall-through FIFO channels (fifo_fwft instances) into one registered valid/ready output stream.
- Grants one channel at a time for bursts of up to BURST_LEN words, then rotates to the next channel that is both enabled and non-empty.
- Sits between the per-source fifo_fwft instances and a single downstream consumer. Each output word is tagged with its source channel.

Parameters:
- NUM_CH, 4, number of channels; legal range 2..16.
- DATA_WIDTH, 8, word width.
- BURST_LEN, 4, maximum words popped per grant; must be >= 1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_empty_i  in  NUM_CH  per-channel FWFT empty flag.
- ch_data_i  in  NUM_CH*DATA_WIDTH  per-channel FWFT dout; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ch_en_i  in  NUM_CH  per-channel enable mask; a disabled channel is never granted.
- ch_rd_en_o  out  NUM_CH  per-channel pop strobe; one-hot or zero.
- out_data_o  out  DATA_WIDTH  registered output word.
- out_ch_o  out  CH_W=$clog2(NUM_CH)  source channel of out_data_o.
- out_valid_o  out  1  output register holds a word.
- out_ready_i  in  1  consumer accepts the word.
- busy_o  out  1  high while the FSM is in GRANT.

Behaviour:
- Reset: out_valid_o=0, out_data_o=0, out_ch_o=0, ch_rd_en_o=0, busy_o=0, state=ARB, burst count=0, last-grant pointer=NUM_CH-1 (so channel 0 has first priority).
- Definitions:
  - slot_free = !out_valid_o || out_ready_i.
  - req[k] = !ch_empty_i[k] && ch_en_i[k].
  - load = (state==GRANT) && req[g] && slot_free, where g is the granted channel.
- ch_rd_en_o[g] = load. ch_rd_en_o is combinational and is never asserted for an empty or disabled channel.
- On load:
  - out_data_o <= ch_data_i[g], out_ch_o <= g, out_valid_o <= 1.
  - Burst count increments.
- If out_ready_i && out_valid_o && !load, out_valid_o <= 0. Data and channel registers hold.
- FSM state ARB:
  - If any req, g <= first requesting channel searching from last_grant+1 upward, with wrap-around modulo NUM_CH. last_grant <= that channel, count <= 0, go to GRANT.
  - Otherwise stay in ARB.
  - Never pops.
- FSM state GRANT:
  - Return to ARB after a load that makes count reach BURST_LEN.
  - Return to ARB in any cycle where req[g]==0 (channel empty or disabled). No pop occurs in that cycle.
  - Backpressure (slot_free==0) holds state and count; it does not end the burst.
- Latency: ch_empty_i falling in cycle 0 (FSM in ARB, output idle) -> GRANT in cycle 1 with pop -> out_valid_o=1 in cycle 2.
- Sustained throughput is one word per cycle within a burst. There is one idle ARB cycle between bursts.
- Ordering: words from one channel leave in FIFO order. The output never duplicates or drops a word.
- Mid-burst disable: the current grant releases on the next evaluation. Words already in the output register are unaffected.
- Single requester: after each burst the FSM returns through ARB and re-grants the same channel.
- BURST_LEN=1 degenerates to per-word round-robin.
- Reset asserted mid-burst clears all state immediately. Any word in the output register is discarded.
- Count width is $clog2(BURST_LEN+1). The pointer increment wraps modulo NUM_CH, including for non-power-of-2 NUM_CH.

Decomposition:
- Package fifo_arb_pkg:
  - State encoding localparams ST_ARB=1'b0, ST_GRANT=1'b1.
  - Width helper function for CH_W and the count width.
- Sub-module fifo_rr_pick (combinational):
  - Inputs: req vector and last-grant pointer.
  - Outputs: found flag and next-grant index.
  - Implemented as a rotate, priority-encode and un-rotate, so it can be tested standalone.

Test Plan:
- Reset, then only channel 2 non-empty holding A0..A5, out_ready_i=1, BURST_LEN=4 -> out A0..A3 tagged ch2, one-cycle gap, then A4, A5. First out_valid_o occurs 2 cycles after reset release.
- All 4 channels each holding 8 words, ready=1 -> grant order 0,1,2,3,0,... with 4-word bursts. Each channel's words appear in order. Total 32 words.
- Channel 1 granted, out_ready_i=0 for 5 cycles mid-burst -> exactly one word held in the output register, no pops during the stall, count frozen. After release, the burst finishes at 4 words.
- Channel 0 runs empty after 2 words while channel 3 holds data -> release after word 2, channel 3 granted next (channels 1 and 2 empty). No pop is ever issued to an empty channel.
- ch_en_i[1] cleared while channel 1 is granted with data remaining -> no further pops from channel 1, rotation to channel 2. Re-enabling channel 1 resumes its data in order.
- rst_n pulsed low mid-burst -> outputs zero asynchronously. After release, channel 0 has priority over channel 3 when both request.
